// File: rtl/oscillator.sv
`default_nettype none
// ============================================================================
//  Module      : oscillator
//  Description : Single-voice tone generator. A 32-bit phase accumulator
//                stepped by freq drives a saw/square/triangle/piano shaper;
//                the raw wave is scaled by an 8-segment stepped gain
//                envelope and a global amplitude, saturated, and registered
//                once per sample tick.
//  Ports       : clk        system clock
//                rstn       asynchronous active-low reset
//                enable     sample-rate strobe; state advances only when 1
//                cmds       [0] voice enable, [1] envelope/phase reset
//                freq       phase increment per tick
//                envelopes  segment i at [48*i +: 48] = {duration[31:0],
//                           gain[15:0]}; gain unsigned Q8.8
//                amplitude  global volume, unsigned Q16.8
//                shape      0 saw, 1 square, 2 triangle, 3 piano, others 0
//                out        signed WIDTH-bit sample
//  Revision    : 1.0 - initial release
// ============================================================================
module oscillator #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable,
   input  logic [7:0]       cmds,
   input  logic [31:0]      freq,
   input  logic [383:0]     envelopes,
   input  logic [23:0]      amplitude,
   input  logic [2:0]       shape,
   output logic [WIDTH-1:0] out
);

   // Scaling runs in one wide signed domain so neither product can overflow.
   localparam int C_WIDE = WIDTH + 42;

   localparam logic signed [WIDTH-1:0] C_OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] C_OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic signed [C_WIDE-1:0] C_SAT_MAX =
      $signed({{(C_WIDE-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
   localparam logic signed [C_WIDE-1:0] C_SAT_MIN =
      $signed({{(C_WIDE-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});

   logic [31:0]      phase_q, phase_d;
   logic [2:0]       seg_q, seg_d;
   logic [31:0]      seg_cnt_q, seg_cnt_d;
   logic [WIDTH-1:0] out_q, out_d;

   logic [15:0]      w_gain [8];
   logic [31:0]      w_dur  [8];

   logic [WIDTH-1:0]        w_p;
   logic [WIDTH-1:0]        w_p2;
   logic signed [WIDTH-1:0] w_saw;
   logic signed [WIDTH-1:0] w_tri1;
   logic signed [WIDTH-1:0] w_tri2;
   logic signed [WIDTH-1:0] w_raw;

   logic signed [C_WIDE-1:0] w_raw_x;
   logic signed [C_WIDE-1:0] w_gain_x;
   logic signed [C_WIDE-1:0] w_amp_x;
   logic signed [C_WIDE-1:0] w_s1;
   logic signed [C_WIDE-1:0] w_s2;
   logic [WIDTH-1:0]         w_sample;
   logic                     w_seg_done;

   logic unused_cmds;
   assign unused_cmds = ^cmds[7:2];

   generate
      for (genvar i = 0; i < 8; i++) begin : g_seg
         assign w_gain[i] = envelopes[48*i +: 16];
         assign w_dur[i]  = envelopes[48*i+16 +: 32];
      end
   endgenerate

   // Triangle from a phase slice: double the slice, mirror the second half,
   // then shift the unsigned ramp to signed by flipping the MSB.
   function automatic logic [WIDTH-1:0] tri_wave(input logic [WIDTH-1:0] p);
      logic [WIDTH-1:0] u;
      u = {p[WIDTH-2:0], 1'b0};
      if (p[WIDTH-1]) begin
         u = ~u;
      end
      return {~u[WIDTH-1], u[WIDTH-2:0]};
   endfunction

   assign w_p  = phase_q[31 -: WIDTH];
   // Slice of 2*phase (mod 2^32) for the second piano harmonic.
   assign w_p2 = phase_q[30 -: WIDTH];

   always_comb begin
      w_saw  = {~w_p[WIDTH-1], w_p[WIDTH-2:0]};
      w_tri1 = tri_wave(w_p);
      w_tri2 = tri_wave(w_p2);
      case (shape)
         3'd0:    w_raw = w_saw;
         3'd1:    w_raw = phase_q[31] ? C_OUT_MIN : C_OUT_MAX;
         3'd2:    w_raw = w_tri1;
         // Weights 1/2 + 1/4 + 1/4 keep the sum inside WIDTH bits, so the
         // WIDTH-bit addition never wraps.
         3'd3:    w_raw = (w_tri1 >>> 1) + (w_tri2 >>> 2) + (w_saw >>> 2);
         default: w_raw = '0;
      endcase
   end

   always_comb begin
      w_raw_x  = {{(C_WIDE-WIDTH){w_raw[WIDTH-1]}}, w_raw};
      w_gain_x = {{(C_WIDE-16){1'b0}}, w_gain[seg_q]};
      w_amp_x  = {{(C_WIDE-24){1'b0}}, amplitude};
      w_s1     = (w_raw_x * w_gain_x) >>> 8;
      w_s2     = (w_s1 * w_amp_x) >>> 8;
      if (w_s2 > C_SAT_MAX) begin
         w_sample = C_OUT_MAX;
      end else if (w_s2 < C_SAT_MIN) begin
         w_sample = C_OUT_MIN;
      end else begin
         w_sample = w_s2[WIDTH-1:0];
      end
   end

   // A zero-duration segment is treated as one tick long.
   assign w_seg_done = (w_dur[seg_q] == 32'd0) ||
                       (seg_cnt_q >= (w_dur[seg_q] - 32'd1));

   always_comb begin
      phase_d   = phase_q;
      seg_d     = seg_q;
      seg_cnt_d = seg_cnt_q;
      out_d     = out_q;
      if (enable) begin
         if (!cmds[0]) begin
            phase_d   = '0;
            seg_d     = '0;
            seg_cnt_d = '0;
            out_d     = '0;
         end else begin
            out_d = w_sample;
            if (cmds[1]) begin
               phase_d   = '0;
               seg_d     = '0;
               seg_cnt_d = '0;
            end else begin
               phase_d = phase_q + freq;
               // The last segment is a sustain: it never advances.
               if (seg_q != 3'd7) begin
                  if (w_seg_done) begin
                     seg_d     = seg_q + 3'd1;
                     seg_cnt_d = '0;
                  end else begin
                     seg_cnt_d = seg_cnt_q + 32'd1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         phase_q   <= '0;
         seg_q     <= '0;
         seg_cnt_q <= '0;
         out_q     <= '0;
      end else begin
         phase_q   <= phase_d;
         seg_q     <= seg_d;
         seg_cnt_q <= seg_cnt_d;
         out_q     <= out_d;
      end
   end

   assign out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_oscillator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oscillator
//  Description : Self-checking bench for oscillator (WIDTH = 24). A
//                behavioural model computes each expected sample from the
//                waveform formulas with plain integer arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oscillator;

   localparam longint H    = 64'sd8388608;   // 2^(WIDTH-1)
   localparam longint MAXV = H - 1;
   localparam longint MINV = -H;

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          enable = 1'b0;
   logic [7:0]    cmds = 8'd0;
   logic [31:0]   freq = 32'd0;
   logic [383:0]  envelopes;
   logic [23:0]   amplitude = 24'd0;
   logic [2:0]    shape = 3'd0;
   logic [23:0]   out;

   logic [15:0]   gain [8];
   logic [31:0]   dur  [8];

   int checks = 0;
   int errors = 0;

   // model state
   logic [31:0]   m_phase = 32'd0;
   int            m_seg = 0;
   longint        m_cnt = 0;
   longint        m_out = 0;

   always #5 clk = ~clk;

   always_comb begin
      envelopes = '0;
      for (int i = 0; i < 8; i++) envelopes[i*48 +: 48] = {dur[i], gain[i]};
   end

   oscillator #(.WIDTH(24)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .enable    (enable),
      .cmds      (cmds),
      .freq      (freq),
      .envelopes (envelopes),
      .amplitude (amplitude),
      .shape     (shape),
      .out       (out)
   );

   function automatic longint floordiv(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint saw_m(input longint p);
      return p - H;
   endfunction

   function automatic longint tri_m(input longint p);
      if (p < H) return 2 * p - H;
      return (2 * H - 1 - 2 * (p - H)) - H;
   endfunction

   function automatic longint sample_m(input logic [31:0] ph, input longint g,
                                       input longint amp, input int sh);
      longint p, p2, raw, s, y;
      logic [31:0] ph2;
      p   = longint'(ph >> 8);
      ph2 = ph << 1;
      p2  = longint'(ph2 >> 8);
      case (sh)
         0: raw = saw_m(p);
         1: raw = (ph < 32'h8000_0000) ? MAXV : MINV;
         2: raw = tri_m(p);
         3: raw = floordiv(tri_m(p), 2) + floordiv(tri_m(p2), 4) + floordiv(saw_m(p), 4);
         default: raw = 0;
      endcase
      s = floordiv(raw * g, 256);
      y = floordiv(s * amp, 256);
      if (y > MAXV) y = MAXV;
      if (y < MINV) y = MINV;
      return y;
   endfunction

   task automatic model_reset();
      m_phase = 32'd0;
      m_seg   = 0;
      m_cnt   = 0;
      m_out   = 0;
   endtask

   task automatic model_tick();
      if (!rstn || !enable) return;
      if (!cmds[0]) begin
         model_reset();
      end else begin
         m_out = sample_m(m_phase, longint'(gain[m_seg]), longint'(amplitude), int'(shape));
         if (cmds[1]) begin
            m_phase = 32'd0;
            m_seg   = 0;
            m_cnt   = 0;
         end else begin
            m_phase = m_phase + freq;
            if (m_seg < 7) begin
               if (m_cnt + 1 >= longint'(dur[m_seg])) begin
                  m_seg = m_seg + 1;
                  m_cnt = 0;
               end else begin
                  m_cnt = m_cnt + 1;
               end
            end
         end
      end
   endtask

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint dut_out();
      return longint'($signed(out));
   endfunction

   task automatic step(input string tag);
      @(posedge clk);
      model_tick();
      #1;
      check(tag, dut_out(), m_out);
   endtask

   initial begin
      longint sq [4];
      longint held;
      sq[0] = MAXV; sq[1] = MAXV; sq[2] = MINV; sq[3] = MINV;
      for (int i = 0; i < 8; i++) begin
         gain[i] = 16'd256;
         dur[i]  = 32'd1000;
      end

      // 1. asynchronous reset with arbitrary inputs
      enable    = 1'b1;
      cmds      = 8'($urandom);
      freq      = $urandom;
      amplitude = 24'($urandom);
      shape     = 3'($urandom);
      #2 rstn = 1'b0;
      #2 check("reset_async", dut_out(), 0);
      @(negedge clk);
      check("reset_held", dut_out(), 0);
      rstn = 1'b1; cmds = 8'd1; freq = 32'd0; shape = 3'd0; amplitude = 24'd256;
      step("first_saw");
      check("first_saw_const", dut_out(), MINV);

      // 2. square at quarter-rate phase step
      freq = 32'h4000_0000; shape = 3'd1;
      for (int k = 0; k < 8; k++) begin
         step("square");
         check("square_const", dut_out(), sq[k % 4]);
      end

      // 3. sawtooth 440 Hz
      freq = 32'd39370534; shape = 3'd0;
      for (int k = 0; k < 240; k++) step("saw440");

      // 4. stepped envelope with square wave
      cmds = 8'd3;
      step("env_restart");
      cmds = 8'd1; freq = 32'h4000_0000; shape = 3'd1; amplitude = 24'd256;
      gain[0] = 16'd100; gain[1] = 16'd200; gain[2] = 16'd300;
      dur[0] = 32'd4800; dur[1] = 32'd4800; dur[2] = 32'd4800;
      for (int k = 1; k <= 9610; k++) begin
         step("envelope");
         if (k == 1)    check("env_seg0", dut_out(), 3276799);
         if (k == 4801) check("env_seg1", dut_out(), 6553599);
         if (k == 9601) check("env_seg2_sat", dut_out(), 8388607);
      end

      // 5. mid-note envelope/phase reset, then gate off
      gain[0] = 16'd100; freq = 32'd39370534; shape = 3'd2;
      for (int k = 0; k < 20; k++) step("tri_pre");
      cmds = 8'd3;
      step("bit1_tick");
      cmds = 8'd1;
      step("bit1_after");
      check("bit1_phase0", dut_out(), -3276800);
      for (int k = 0; k < 10; k++) step("tri_post");
      cmds = 8'd0;
      for (int k = 0; k < 10; k++) begin
         step("gate_off");
         check("gate_off_zero", dut_out(), 0);
      end

      // 6. piano with a random preset, then enable=0 freeze
      cmds = 8'd1; shape = 3'd3; amplitude = 24'd200; freq = 32'd39370534;
      for (int i = 0; i < 8; i++) begin
         gain[i] = 16'($urandom_range(0, 400));
         dur[i]  = 32'($urandom_range(1, 8));
      end
      for (int k = 0; k < 29; k++) step("piano");
      held = m_out;
      enable = 1'b0; freq = $urandom; shape = 3'd1;
      for (int k = 0; k < 5; k++) begin
         step("freeze");
         check("freeze_hold", dut_out(), held);
      end

      // asynchronous reset mid-run
      enable = 1'b1; shape = 3'd0;
      step("pre_areset");
      #2 rstn = 1'b0;
      #1 check("areset_mid", dut_out(), 0);
      model_reset();
      rstn = 1'b1;
      step("post_areset");

      // randomized sweep
      for (int i = 0; i < 8; i++) dur[i] = 32'($urandom_range(0, 6));
      for (int k = 0; k < 3000; k++) begin
         enable = ($urandom_range(0, 9) != 0);
         cmds   = 8'($urandom) & 8'hFC;
         cmds[0] = ($urandom_range(0, 19) != 0);
         cmds[1] = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 15) == 0) shape = 3'($urandom);
         if ($urandom_range(0, 7) == 0)  freq = $urandom;
         amplitude = 24'($urandom_range(0, 600));
         if ($urandom_range(0, 31) == 0) amplitude = 24'($urandom);
         gain[$urandom_range(0, 7)] = 16'($urandom);
         step("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
